rc4_encrypt: RTL and testbench

RC4_ENCRYPT -- requirements
Module: rc4_encrypt

---
 rtl/rc4_encrypt.sv | 135 +++++++++++++
 tb/tb_rc4_encrypt.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_encrypt.sv
// rc4_encrypt: RC4 stream cipher, one plaintext byte in, one ciphertext byte out.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   key_byte   key byte, key[0] first, qualified by key_valid (LOAD only)
//   key_valid  key_byte qualifier
//   rekey      single-cycle request to drop the current key and reload it
//   data_in    plaintext byte, qualified by valid
//   valid      data_in qualifier; taken only while in_ready is high
//   in_ready   high in READY, when a plaintext byte can be accepted
//   init_done  high while the keystream generator is keyed (READY/GEN)
//   data_out   ciphertext byte, zero whenever out_valid is low
//   out_valid  one-cycle pulse qualifying data_out
//
// Flow: LOAD (KEY_LEN key bytes) -> FILL (S[n]=n) -> KSA (256 cycles) -> READY.
// An accepted byte spends one cycle in GEN; the result is registered on the
// GEN edge, so out_valid and in_ready are high together in the following cycle.
module rc4_encrypt #(
    parameter int KEY_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_byte,
    input  logic       key_valid,
    input  logic       rekey,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       in_ready,
    output logic       init_done,
    output logic [7:0] data_out,
    output logic       out_valid
);

    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(KEY_LEN - 1);

    typedef enum logic [2:0] {LOAD, FILL, KSA, READY, GEN} state_t;

    state_t      state, next_state;
    logic [KW-1:0] k;          // key byte counter in LOAD, key index in KSA
    logic [7:0]  i, j;
    logic [7:0]  din_q;
    logic [7:0]  key_mem [KEY_LEN];
    logic [7:0]  sbox    [256];

    logic [7:0]  ksa_j, gen_i, gen_j, ks_idx;
    logic        accept;

    assign ksa_j  = j + sbox[i] + key_mem[k];
    assign gen_i  = i + 8'd1;
    assign gen_j  = j + sbox[gen_i];
    // i/j already hold the post-swap indices while in GEN
    assign ks_idx = sbox[i] + sbox[j];
    assign accept = (state == READY) && valid && !rekey;

    assign in_ready  = (state == READY);
    assign init_done = (state == READY) || (state == GEN);

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (key_valid && k == K_LAST) next_state = FILL;
            FILL:    next_state = KSA;
            KSA:     if (i == 8'd255) next_state = READY;
            READY:   if (valid) next_state = GEN;
            GEN:     next_state = READY;
            default: next_state = LOAD;
        endcase
        if (rekey) next_state = LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            k         <= '0;
            i         <= 8'd0;
            j         <= 8'd0;
            din_q     <= 8'd0;
            data_out  <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            out_valid <= 1'b0;
            data_out  <= 8'd0;
            if (rekey) begin
                k <= '0;
                i <= 8'd0;
                j <= 8'd0;
            end else begin
                case (state)
                    LOAD: if (key_valid) k <= (k == K_LAST) ? '0 : k + 1'b1;
                    FILL: begin
                        k <= '0;
                        i <= 8'd0;
                        j <= 8'd0;
                    end
                    KSA: begin
                        k <= (k == K_LAST) ? '0 : k + 1'b1;
                        i <= i + 8'd1;   // wraps to 0 after 255
                        j <= (i == 8'd255) ? 8'd0 : ksa_j;
                    end
                    READY: if (valid) begin
                        i     <= gen_i;
                        j     <= gen_j;
                        din_q <= data_in;
                    end
                    GEN: begin
                        out_valid <= 1'b1;
                        data_out  <= sbox[ks_idx] ^ din_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Key store and S-box carry no reset; FILL/KSA define their contents.
    always_ff @(posedge clk) begin
        if (!rst && !rekey) begin
            if (state == LOAD && key_valid)
                key_mem[k] <= key_byte;
            if (state == FILL) begin
                for (int n = 0; n < 256; n++) sbox[n] <= 8'(n);
            end else if (state == KSA) begin
                sbox[i]     <= sbox[ksa_j];
                sbox[ksa_j] <= sbox[i];
            end else if (accept) begin
                sbox[gen_i] <= sbox[gen_j];
                sbox[gen_j] <= sbox[gen_i];
            end
        end
    end

endmodule

// File: tb/tb_rc4_encrypt.sv
module tb_rc4_encrypt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key_byte = 8'd0;
    logic       key_valid = 1'b0;
    logic       rekey = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       valid = 1'b0;

    logic       ir3, id3, ov3, ir4, id4, ov4;
    logic [7:0] do3, do4;

    // sel picks which instance the stream/wait tasks observe (0: KEY_LEN=3, 1: KEY_LEN=4)
    logic       sel = 1'b0;
    logic       ir, id, ov;
    logic [7:0] dout;
    assign ir   = sel ? ir4 : ir3;
    assign id   = sel ? id4 : id3;
    assign ov   = sel ? ov4 : ov3;
    assign dout = sel ? do4 : do3;

    int total = 0;
    int bad   = 0;

    logic [7:0] key_q[$];
    logic [7:0] pt_q[$];
    logic [7:0] out_q[$];
    logic [7:0] ks_q[$];
    logic [7:0] exp_q[$];

    rc4_encrypt #(.KEY_LEN(3)) dut3 (
        .clk(clk), .rst(rst), .key_byte(key_byte), .key_valid(key_valid), .rekey(rekey),
        .data_in(data_in), .valid(valid), .in_ready(ir3), .init_done(id3),
        .data_out(do3), .out_valid(ov3)
    );

    rc4_encrypt #(.KEY_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .key_byte(key_byte), .key_valid(key_valid), .rekey(rekey),
        .data_in(data_in), .valid(valid), .in_ready(ir4), .init_done(id4),
        .data_out(do4), .out_valid(ov4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rekey();
        rekey = 1'b1;
        step();
        rekey = 1'b0;
    endtask

    task automatic load_key();
        foreach (key_q[n]) begin
            key_byte  = key_q[n];
            key_valid = 1'b1;
            step();
        end
        key_valid = 1'b0;
    endtask

    task automatic wait_init(output int cnt);
        cnt = 0;
        while (id !== 1'b1 && cnt < 400) begin
            step();
            cnt++;
        end
    endtask

    // Textbook RC4: KSA then PRGA, n keystream bytes into ks_q
    task automatic rc4_model(input int n);
        int s[256];
        int ii, jj, t;
        ks_q = {};
        for (int m = 0; m < 256; m++) s[m] = m;
        jj = 0;
        for (int m = 0; m < 256; m++) begin
            jj = (jj + s[m] + int'(key_q[m % key_q.size()])) % 256;
            t = s[m]; s[m] = s[jj]; s[jj] = t;
        end
        ii = 0; jj = 0;
        for (int m = 0; m < n; m++) begin
            ii = (ii + 1) % 256;
            jj = (jj + s[ii]) % 256;
            t = s[ii]; s[ii] = s[jj]; s[jj] = t;
            ks_q.push_back(8'(s[(s[ii] + s[jj]) % 256]));
        end
    endtask

    // Streams pt_q through the selected instance; protocol anomalies are
    // counted (latency, in_ready, idle-zero output, accept timeouts).
    task automatic stream_drive(input bit gaps, output int anom);
        int wt;
        anom  = 0;
        out_q = {};
        foreach (pt_q[n]) begin
            wt = 0;
            while (ir !== 1'b1 && wt < 20) begin
                step();
                wt++;
            end
            if (wt >= 20) anom++;
            valid   = 1'b1;
            data_in = pt_q[n];
            step();
            valid   = 1'b0;
            data_in = 8'($urandom);
            if (ov !== 1'b0 || ir !== 1'b0 || dout !== 8'd0) anom++;
            step();
            if (ov !== 1'b1 || ir !== 1'b1) anom++;
            out_q.push_back(dout);
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    step();
                    if (ov !== 1'b0 || dout !== 8'd0) anom++;
                end
            end
        end
    endtask

    function automatic void set_key_ascii();
        key_q = '{8'h4B, 8'h65, 8'h79};                               // "Key"
    endfunction

    function automatic void set_plaintext();
        pt_q  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        exp_q = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rekey = 1'b1;           // rst wins over rekey
        valid = 1'b1;
        step();
        step();
        rekey = 1'b0;
        valid = 1'b0;
        total++;
        if ({ir3, id3, ov3, do3} !== 11'd0) begin
            bad++;
            $display("FAIL reset_k3: got ir=%b id=%b ov=%b do=%h want all 0", ir3, id3, ov3, do3);
        end
        total++;
        if ({ir4, id4, ov4, do4} !== 11'd0) begin
            bad++;
            $display("FAIL reset_k4: got ir=%b id=%b ov=%b do=%h want all 0", ir4, id4, ov4, do4);
        end
        rst = 1'b0;
        valid = 1'b1;           // valid in LOAD is ignored
        step();
        valid = 1'b0;
        total++;
        if ({ir3, id3, ov3, do3} !== 11'd0) begin
            bad++;
            $display("FAIL valid_in_load: got ir=%b id=%b ov=%b do=%h want all 0", ir3, id3, ov3, do3);
        end
    endtask

    task automatic test_known_key();
        int cnt, anom;
        sel = 1'b0;
        do_rekey();
        set_key_ascii();
        load_key();
        total++;
        if (id !== 1'b0) begin
            bad++;
            $display("FAIL key_init_early: got init_done=%b want 0", id);
        end
        wait_init(cnt);
        total++;
        if (cnt != 257) begin
            bad++;
            $display("FAIL key_init_latency: got %0d edges want 257", cnt);
        end
        set_plaintext();
        stream_drive(1'b0, anom);
        total++;
        if (anom != 0 || out_q.size() != 9) begin
            bad++;
            $display("FAIL key_stream_protocol: got anomalies=%0d outputs=%0d want 0 and 9", anom, out_q.size());
        end
        foreach (exp_q[n]) begin
            total++;
            if (n >= out_q.size() || out_q[n] !== exp_q[n]) begin
                bad++;
                $display("FAIL key_ct[%0d]: got %h want %h", n, (n < out_q.size()) ? out_q[n] : 8'hxx, exp_q[n]);
            end
        end
    endtask

    task automatic test_wiki();
        int cnt, anom;
        sel = 1'b1;
        do_rekey();
        key_q = '{8'h57, 8'h69, 8'h6B, 8'h69};                        // "Wiki"
        load_key();
        wait_init(cnt);
        total++;
        if (cnt != 257) begin
            bad++;
            $display("FAIL wiki_init_latency: got %0d edges want 257", cnt);
        end
        pt_q  = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};                 // "pedia"
        exp_q = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
        stream_drive(1'b1, anom);
        total++;
        if (anom != 0 || out_q.size() != 5) begin
            bad++;
            $display("FAIL wiki_protocol: got anomalies=%0d outputs=%0d want 0 and 5", anom, out_q.size());
        end
        foreach (exp_q[n]) begin
            total++;
            if (n >= out_q.size() || out_q[n] !== exp_q[n]) begin
                bad++;
                $display("FAIL wiki_ct[%0d]: got %h want %h", n, (n < out_q.size()) ? out_q[n] : 8'hxx, exp_q[n]);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cnt, accepted, got;
        logic [7:0] acc_q[$];
        sel = 1'b0;
        do_rekey();
        key_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
        load_key();
        wait_init(cnt);
        acc_q = {};
        out_q = {};
        valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            data_in = 8'($urandom);
            if (ir === 1'b1) acc_q.push_back(data_in);
            step();
            if (ov === 1'b1) out_q.push_back(dout);
        end
        valid = 1'b0;
        repeat (3) begin
            step();
            if (ov === 1'b1) out_q.push_back(dout);
        end
        accepted = acc_q.size();
        got = out_q.size();
        total++;
        if (accepted != 15 || got != accepted) begin
            bad++;
            $display("FAIL b2b_counts: got accepted=%0d outputs=%0d want 15 and 15", accepted, got);
        end
        rc4_model(accepted);
        for (int n = 0; n < accepted && n < got; n++) begin
            total++;
            if (out_q[n] !== (acc_q[n] ^ ks_q[n])) begin
                bad++;
                $display("FAIL b2b_ct[%0d]: got %h want %h", n, out_q[n], acc_q[n] ^ ks_q[n]);
            end
        end
    endtask

    task automatic test_rekey_gen();
        int cnt, anom, stray;
        sel = 1'b0;
        stray = 0;
        do_rekey();
        set_key_ascii();
        load_key();
        wait_init(cnt);
        // rekey together with an accept: byte must not be taken
        valid = 1'b1; rekey = 1'b1; data_in = 8'h5A;
        step();
        valid = 1'b0; rekey = 1'b0;
        repeat (3) begin
            if (ov !== 1'b0 || dout !== 8'd0 || id !== 1'b0) stray++;
            step();
        end
        // rekey in the cycle after the accept: in-flight byte dropped
        load_key();
        wait_init(cnt);
        valid = 1'b1; data_in = 8'hA5;
        step();
        valid = 1'b0; rekey = 1'b1;
        step();
        rekey = 1'b0;
        repeat (3) begin
            if (ov !== 1'b0 || dout !== 8'd0 || id !== 1'b0) stray++;
            step();
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rekey_drop: got %0d stray output/init cycles want 0", stray);
        end
        load_key();
        wait_init(cnt);
        set_plaintext();
        stream_drive(1'b0, anom);
        total++;
        if (anom != 0 || out_q.size() != 9) begin
            bad++;
            $display("FAIL rekey_protocol: got anomalies=%0d outputs=%0d want 0 and 9", anom, out_q.size());
        end
        for (int n = 0; n < 3 && n < out_q.size(); n++) begin
            total++;
            if (out_q[n] !== exp_q[n]) begin
                bad++;
                $display("FAIL rekey_ct[%0d]: got %h want %h", n, out_q[n], exp_q[n]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int cnt, anom, stray;
        sel = 1'b0;
        stray = 0;
        do_rekey();
        set_key_ascii();
        load_key();
        wait_init(cnt);
        valid = 1'b1; data_in = 8'h33;
        step();                 // accepted, now in GEN
        valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) begin
            if (ov !== 1'b0 || dout !== 8'd0) stray++;
            step();
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL reset_mid_gen: got %0d stray output cycles want 0", stray);
        end
        load_key();
        repeat (100) step();
        rst = 1'b1;
        step();
        total++;
        if ({ir3, id3, ov3, do3} !== 11'd0) begin
            bad++;
            $display("FAIL reset_mid_ksa: got ir=%b id=%b ov=%b do=%h want all 0", ir3, id3, ov3, do3);
        end
        rst = 1'b0;
        load_key();
        wait_init(cnt);
        set_plaintext();
        stream_drive(1'b0, anom);
        total++;
        if (anom != 0 || out_q.size() != 9) begin
            bad++;
            $display("FAIL reset_reload_protocol: got anomalies=%0d outputs=%0d want 0 and 9", anom, out_q.size());
        end
        foreach (exp_q[n]) begin
            total++;
            if (n >= out_q.size() || out_q[n] !== exp_q[n]) begin
                bad++;
                $display("FAIL reset_reload_ct[%0d]: got %h want %h", n, (n < out_q.size()) ? out_q[n] : 8'hxx, exp_q[n]);
            end
        end
    endtask

    task automatic test_ignore();
        int cnt, anom, stray;
        sel = 1'b0;
        stray = 0;
        do_rekey();
        set_key_ascii();
        valid = 1'b1;           // held through LOAD, FILL and KSA
        load_key();
        cnt = 0;
        while (id !== 1'b1 && cnt < 400) begin
            if (ov !== 1'b0 || ir !== 1'b0) stray++;
            step();
            cnt++;
        end
        valid = 1'b0;
        total++;
        if (cnt != 257 || stray != 0) begin
            bad++;
            $display("FAIL ignore_valid_ksa: got latency=%0d stray=%0d want 257 and 0", cnt, stray);
        end
        key_byte = 8'($urandom); key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        total++;
        if (ir !== 1'b1 || id !== 1'b1 || ov !== 1'b0) begin
            bad++;
            $display("FAIL ignore_key_ready: got ir=%b id=%b ov=%b want 1 1 0", ir, id, ov);
        end
        set_plaintext();
        stream_drive(1'b1, anom);
        total++;
        if (anom != 0 || out_q.size() != 9) begin
            bad++;
            $display("FAIL ignore_protocol: got anomalies=%0d outputs=%0d want 0 and 9", anom, out_q.size());
        end
        foreach (exp_q[n]) begin
            total++;
            if (n >= out_q.size() || out_q[n] !== exp_q[n]) begin
                bad++;
                $display("FAIL ignore_ct[%0d]: got %h want %h", n, (n < out_q.size()) ? out_q[n] : 8'hxx, exp_q[n]);
            end
        end
    endtask

    task automatic test_random();
        int cnt, anom, len;
        sel = 1'b0;
        for (int r = 0; r < 4; r++) begin
            do_rekey();
            key_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
            load_key();
            wait_init(cnt);
            len = $urandom_range(5, 12);
            pt_q = {};
            repeat (len) pt_q.push_back(8'($urandom));
            stream_drive(1'b1, anom);
            rc4_model(len);
            total++;
            if (anom != 0 || out_q.size() != len || cnt != 257) begin
                bad++;
                $display("FAIL rand%0d_protocol: got anomalies=%0d outputs=%0d latency=%0d want 0 %0d 257",
                         r, anom, out_q.size(), cnt, len);
            end
            for (int n = 0; n < len && n < out_q.size(); n++) begin
                total++;
                if (out_q[n] !== (pt_q[n] ^ ks_q[n])) begin
                    bad++;
                    $display("FAIL rand%0d_ct[%0d]: got %h want %h", r, n, out_q[n], pt_q[n] ^ ks_q[n]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_key();
        test_wiki();
        test_back_to_back();
        test_rekey_gen();
        test_reset_abort();
        test_ignore();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
